// File: rtl/i2c_apb_regs_v2.sv
// rtl/i2c_apb_regs_v2.sv - APB3 register file for the I2C master and its FIFOs
// Optional interrupt output enabled by defining I2C_APB_REGS_IRQ_EN.
module i2c_apb_regs_v2 #(
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 8,
    parameter int DIV_W  = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic [7:0]        tx_data,
    output logic              tx_push,
    input  logic              tx_full,
    input  logic [7:0]        rx_data,
    output logic              rx_pop,
    input  logic              rx_empty,
    output logic [7:0]        slv_addr,
    output logic [CNT_W-1:0]  byte_cnt,
    output logic [DIV_W-1:0]  prescale,
    output logic              i2c_start,
    input  logic              i2c_done,
    input  logic              i2c_nack,
    output logic              irq
);
    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_BUSY} state_t;

    state_t      state;
    logic        st_done, st_nack, st_ovf, st_udf;
    logic        irq_en;
    logic        access, busy, err, wr_ok, rd_ok;
    logic [31:0] idx, rdata;
    logic        unused_bits;

    assign access      = PSEL & PENABLE;
    assign busy        = (state != ST_IDLE);
    assign idx         = 32'(PADDR[ADDR_W-1:2]);
    assign PREADY      = 1'b1;
    assign unused_bits = ^{PADDR[1:0], PWDATA};

    always_comb begin
        err   = 1'b0;
        rdata = 32'd0;
        if (access) begin
            case (idx)
                32'd0: if (PWRITE && busy) err = 1'b1;
                       else rdata = {24'd0, slv_addr};
                32'd1: if (!PWRITE || tx_full) err = 1'b1;
                32'd2: if (PWRITE && busy) err = 1'b1;
                       else rdata = 32'(byte_cnt);
                32'd3: rdata = {25'd0, st_udf, st_ovf, busy, rx_empty, tx_full, st_nack, st_done};
                32'd4: if (PWRITE && PWDATA[0] && busy) err = 1'b1;
                       else rdata = {30'd0, irq_en, 1'b0};
                32'd5: if (PWRITE || rx_empty) err = 1'b1;
                       else rdata = {24'd0, rx_data};
                32'd6: if (PWRITE && busy) err = 1'b1;
                       else rdata = 32'(prescale);
                default: err = 1'b1;
            endcase
        end
        PSLVERR = err;
        PRDATA  = (err || PWRITE) ? 32'd0 : rdata;
    end

    assign wr_ok = access & PWRITE & ~err;
    assign rd_ok = access & ~PWRITE & ~err;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state     <= ST_IDLE;
            slv_addr  <= '0;
            byte_cnt  <= '0;
            prescale  <= '0;
            tx_data   <= '0;
            tx_push   <= 1'b0;
            rx_pop    <= 1'b0;
            i2c_start <= 1'b0;
            st_done   <= 1'b0;
            st_nack   <= 1'b0;
            st_ovf    <= 1'b0;
            st_udf    <= 1'b0;
        end else begin
            tx_push   <= 1'b0;
            rx_pop    <= 1'b0;
            i2c_start <= 1'b0;
            if (wr_ok) begin
                case (idx)
                    32'd0: slv_addr <= PWDATA[7:0];
                    32'd1: begin
                        tx_data <= PWDATA[7:0];
                        tx_push <= 1'b1;
                    end
                    32'd2: byte_cnt <= PWDATA[CNT_W-1:0];
                    32'd6: prescale <= PWDATA[DIV_W-1:0];
                    default: ;
                endcase
            end
            if (rd_ok && idx == 32'd5)
                rx_pop <= 1'b1;

            // Hardware set terms are OR'ed after the clear so they win a same-cycle W1C.
            st_done <= (st_done & ~(wr_ok && idx == 32'd3 && PWDATA[0]))
                     | (state == ST_BUSY && i2c_done);
            st_nack <= (st_nack & ~(wr_ok && idx == 32'd3 && PWDATA[1])) | i2c_nack;
            st_ovf  <= (st_ovf & ~(wr_ok && idx == 32'd3 && PWDATA[5]))
                     | (access && PWRITE && idx == 32'd1 && tx_full);
            st_udf  <= (st_udf & ~(wr_ok && idx == 32'd3 && PWDATA[6]))
                     | (access && !PWRITE && idx == 32'd5 && rx_empty);

            case (state)
                ST_IDLE: if (wr_ok && idx == 32'd4 && PWDATA[0]) begin
                    state     <= ST_START;
                    i2c_start <= 1'b1;
                end
                ST_START: state <= ST_BUSY;
                ST_BUSY:  if (i2c_done) state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

`ifdef I2C_APB_REGS_IRQ_EN
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            irq_en <= 1'b0;
            irq    <= 1'b0;
        end else begin
            if (wr_ok && idx == 32'd4)
                irq_en <= PWDATA[1];
            irq <= irq_en & (st_done | st_nack | st_ovf | st_udf);
        end
    end
`else
    assign irq_en = 1'b0;
    assign irq    = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_apb_regs_v2.sv
// tb/tb_i2c_apb_regs_v2.sv - randomized self-checking bench for i2c_apb_regs_v2
module tb_i2c_apb_regs_v2;
    localparam int ADDR_W = 5;
    localparam int CNT_W  = 8;
    localparam int DIV_W  = 16;
`ifdef I2C_APB_REGS_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic              PCLK = 1'b0, PRESETn = 1'b0;
    logic              PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
    logic [ADDR_W-1:0] PADDR = '0;
    logic [31:0]       PWDATA = '0;
    logic [31:0]       PRDATA;
    logic              PREADY, PSLVERR;
    logic [7:0]        tx_data;
    logic              tx_push;
    logic              tx_full = 1'b0;
    logic [7:0]        rx_data = 8'd0;
    logic              rx_pop;
    logic              rx_empty = 1'b1;
    logic [7:0]        slv_addr;
    logic [CNT_W-1:0]  byte_cnt;
    logic [DIV_W-1:0]  prescale;
    logic              i2c_start;
    logic              i2c_done = 1'b0, i2c_nack = 1'b0;
    logic              irq;

    i2c_apb_regs_v2 #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .DIV_W(DIV_W)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .tx_data(tx_data), .tx_push(tx_push), .tx_full(tx_full), .rx_data(rx_data),
        .rx_pop(rx_pop), .rx_empty(rx_empty), .slv_addr(slv_addr), .byte_cnt(byte_cnt),
        .prescale(prescale), .i2c_start(i2c_start), .i2c_done(i2c_done), .i2c_nack(i2c_nack),
        .irq(irq)
    );

    always #5 PCLK = ~PCLK;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: transfer phase 0 idle, 1 start pulse pending, 2 busy
    int          m_phase;
    logic [7:0]  m_slv, m_tx;
    logic [31:0] m_cnt, m_div;
    bit          m_done, m_nack, m_ovf, m_udf, m_en, m_irq;

    function automatic void m_reset();
        m_phase = 0; m_slv = 0; m_tx = 0; m_cnt = 0; m_div = 0;
        m_done = 0; m_nack = 0; m_ovf = 0; m_udf = 0; m_en = 0; m_irq = 0;
    endfunction

    function automatic void m_irq_update();
        m_irq = IRQ_ON && m_en && (m_done || m_nack || m_ovf || m_udf);
    endfunction

    // Clock edge with no APB access
    function automatic void m_edge(input bit done_in, input bit nack_in);
        m_irq_update();
        if (nack_in) m_nack = 1;
        if (m_phase == 2 && done_in) begin
            m_done  = 1;
            m_phase = 0;
        end else if (m_phase == 1) begin
            m_phase = 2;
        end
    endfunction

    function automatic void m_access(input bit w, input int idx, input logic [31:0] d,
                                     input bit txf, input bit rxe, input logic [7:0] rxd,
                                     output bit err, output logic [31:0] rd,
                                     output bit push, output bit pop, output bit start);
        bit busy;
        busy = (m_phase != 0);
        err = 0; rd = 0; push = 0; pop = 0; start = 0;
        case (idx)
            0: if (w && busy) err = 1; else rd = {24'd0, m_slv};
            1: err = !w || txf;
            2: if (w && busy) err = 1; else rd = m_cnt;
            3: rd = {25'd0, m_udf, m_ovf, busy, rxe, txf, m_nack, m_done};
            4: if (w && d[0] && busy) err = 1; else rd = {30'd0, m_en, 1'b0};
            5: if (w || rxe) err = 1; else rd = {24'd0, rxd};
            6: if (w && busy) err = 1; else rd = m_div;
            default: err = 1;
        endcase
        if (err || w) rd = 0;
        m_irq_update();
        if (w && !err) begin
            case (idx)
                0: m_slv = d[7:0];
                1: begin push = 1; m_tx = d[7:0]; end
                2: m_cnt = d % (32'd1 << CNT_W);
                3: begin
                    if (d[0]) m_done = 0;
                    if (d[1]) m_nack = 0;
                    if (d[5]) m_ovf = 0;
                    if (d[6]) m_udf = 0;
                end
                4: begin
                    if (IRQ_ON) m_en = d[1];
                    if (d[0]) begin m_phase = 1; start = 1; end
                end
                6: m_div = d % (32'd1 << DIV_W);
                default: ;
            endcase
        end
        if (!w && !err && idx == 5) pop = 1;
        if (w && idx == 1 && txf) m_ovf = 1;
        if (!w && idx == 5 && rxe) m_udf = 1;
    endfunction

    task automatic xfer(input bit w, input logic [ADDR_W-1:0] addr, input logic [31:0] d,
                        input bit txf, input bit rxe, input logic [7:0] rxd,
                        output logic [31:0] a_rd, output bit a_err);
        bit e_err, e_push, e_pop, e_start;
        logic [31:0] e_rd;
        @(negedge PCLK);
        PSEL = 1; PENABLE = 0; PWRITE = w; PADDR = addr; PWDATA = d;
        tx_full = txf; rx_empty = rxe; rx_data = rxd;
        @(negedge PCLK);
        m_edge(0, 0);
        PENABLE = 1;
        #1;
        a_rd = PRDATA; a_err = PSLVERR;
        m_access(w, int'(addr[ADDR_W-1:2]), d, txf, rxe, rxd, e_err, e_rd, e_push, e_pop, e_start);
        n_tests++;
        if (a_err !== e_err) begin
            n_fail++; $display("FAIL pslverr addr=%h w=%0d got %0b exp %0b", addr, w, a_err, e_err);
        end
        if (!w) begin
            n_tests++;
            if (a_rd !== e_rd) begin
                n_fail++; $display("FAIL prdata addr=%h got %h exp %h", addr, a_rd, e_rd);
            end
        end
        @(posedge PCLK);
        #1;
        PSEL = 0; PENABLE = 0;
        n_tests++;
        if (tx_push !== e_push || rx_pop !== e_pop || i2c_start !== e_start) begin
            n_fail++;
            $display("FAIL pulses push/pop/start got %b%b%b exp %b%b%b",
                     tx_push, rx_pop, i2c_start, e_push, e_pop, e_start);
        end
        n_tests++;
        if (slv_addr !== m_slv || 32'(byte_cnt) !== m_cnt || 32'(prescale) !== m_div ||
            tx_data !== m_tx || irq !== m_irq) begin
            n_fail++;
            $display("FAIL outputs slv/cnt/div/tx/irq got %h/%h/%h/%h/%b exp %h/%h/%h/%h/%b",
                     slv_addr, byte_cnt, prescale, tx_data, irq, m_slv, m_cnt, m_div, m_tx, m_irq);
        end
    endtask

    task automatic idle_cycle(input bit done_in, input bit nack_in);
        @(negedge PCLK);
        i2c_done = done_in; i2c_nack = nack_in;
        @(posedge PCLK);
        m_edge(done_in, nack_in);
        #1;
        i2c_done = 0; i2c_nack = 0;
        n_tests++;
        if (irq !== m_irq || i2c_start !== 1'b0 || tx_push !== 1'b0 || rx_pop !== 1'b0) begin
            n_fail++;
            $display("FAIL idle irq/start/push/pop got %b%b%b%b exp %b000",
                     irq, i2c_start, tx_push, rx_pop, m_irq);
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd; bit e;
        m_reset();
        #12;
        n_tests++;
        if (slv_addr !== 0 || byte_cnt !== 0 || prescale !== 0 || tx_data !== 0 || tx_push !== 0 ||
            rx_pop !== 0 || i2c_start !== 0 || irq !== 0 || PREADY !== 1 || PSLVERR !== 0) begin
            n_fail++; $display("FAIL reset_outputs slv=%h cnt=%h div=%h irq=%b pready=%b pslverr=%b",
                               slv_addr, byte_cnt, prescale, irq, PREADY, PSLVERR);
        end
        @(negedge PCLK);
        PRESETn = 1;
        xfer(0, 5'h00, 0, 0, 1, 0, rd, e);
        xfer(0, 5'h08, 0, 0, 1, 0, rd, e);
        xfer(0, 5'h10, 0, 0, 1, 0, rd, e);
        xfer(0, 5'h18, 0, 0, 1, 0, rd, e);
        xfer(0, 5'h0C, 0, 0, 1, 0, rd, e);
        n_tests++;
        if (rd !== 32'h08) begin
            n_fail++; $display("FAIL reset_status got %h exp 00000008", rd);
        end
    endtask

    task automatic test_transfer();
        logic [31:0] rd; bit e;
        xfer(1, 5'h00, 32'hA4, 0, 1, 0, rd, e);
        xfer(1, 5'h08, 32'd3, 0, 1, 0, rd, e);
        xfer(1, 5'h18, 32'h1F4, 0, 1, 0, rd, e);
        xfer(1, 5'h10, 32'h1, 0, 1, 0, rd, e);
        idle_cycle(0, 0);
        xfer(0, 5'h0C, 0, 0, 1, 0, rd, e);
        n_tests++;
        if (rd !== 32'h18) begin
            n_fail++; $display("FAIL busy_status got %h exp 00000018", rd);
        end
        xfer(0, 5'h1C, 0, 0, 1, 0, rd, e);
        xfer(1, 5'h00, 32'h55, 0, 1, 0, rd, e);
        n_tests++;
        if (e !== 1'b1 || slv_addr !== 8'hA4) begin
            n_fail++; $display("FAIL busy_write err=%b slv=%h exp 1 a4", e, slv_addr);
        end
        xfer(1, 5'h10, 32'h1, 0, 1, 0, rd, e);
        idle_cycle(1, 0);
        xfer(0, 5'h0C, 0, 0, 1, 0, rd, e);
        n_tests++;
        if (rd !== 32'h09) begin
            n_fail++; $display("FAIL done_status got %h exp 00000009", rd);
        end
        xfer(1, 5'h0C, 32'h1, 0, 1, 0, rd, e);
        xfer(0, 5'h0C, 0, 0, 1, 0, rd, e);
        xfer(1, 5'h10, 32'h3, 0, 1, 0, rd, e);
        idle_cycle(0, 1);
        idle_cycle(1, 0);
        idle_cycle(0, 0);
        idle_cycle(0, 0);
    endtask

    task automatic test_fifo();
        logic [31:0] rd; bit e;
        xfer(1, 5'h04, 32'h5A, 1, 1, 0, rd, e);
        xfer(0, 5'h0C, 0, 0, 1, 0, rd, e);
        n_tests++;
        if (rd[5] !== 1'b1) begin
            n_fail++; $display("FAIL tx_ovf got %b exp 1", rd[5]);
        end
        xfer(1, 5'h04, 32'h5A, 0, 1, 0, rd, e);
        xfer(0, 5'h14, 0, 0, 0, 8'h3C, rd, e);
        n_tests++;
        if (rd !== 32'h3C) begin
            n_fail++; $display("FAIL rxdata got %h exp 0000003c", rd);
        end
        xfer(0, 5'h14, 0, 0, 1, 8'h3C, rd, e);
        xfer(0, 5'h04, 0, 0, 1, 0, rd, e);
        xfer(1, 5'h14, 32'h1, 0, 0, 8'h11, rd, e);
        xfer(0, 5'h0C, 0, 1, 1, 0, rd, e);
        xfer(1, 5'h0C, 32'h63, 0, 1, 0, rd, e);
        xfer(0, 5'h0C, 0, 0, 0, 0, rd, e);
    endtask

    task automatic test_random();
        logic [31:0] rd, d; bit e, w;
        int idx;
        for (int i = 0; i < 400; i++) begin
            idx = $urandom_range(0, 7);
            w   = $urandom_range(0, 1);
            d   = $urandom;
            if (idx == 4 && $urandom_range(0, 1) == 0) d[0] = 1'b0;
            xfer(w, {idx[2:0], 2'($urandom_range(0, 3))}, d, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) == 0, 8'($urandom), rd, e);
            if ($urandom_range(0, 1) == 1)
                idle_cycle($urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; bit e;
        for (int i = 0; i < 8 && m_phase != 0; i++) idle_cycle(1, 0);
        xfer(1, 5'h04, 32'h77, 1, 1, 0, rd, e);
        xfer(1, 5'h10, 32'h1, 0, 1, 0, rd, e);
        #1 PRESETn = 0;
        #1;
        m_reset();
        n_tests++;
        if (i2c_start !== 1'b0 || irq !== 1'b0 || slv_addr !== 8'h0) begin
            n_fail++; $display("FAIL async_reset start=%b irq=%b slv=%h exp 0 0 00", i2c_start, irq, slv_addr);
        end
        @(negedge PCLK);
        PRESETn = 1;
        xfer(0, 5'h0C, 0, 0, 1, 0, rd, e);
        n_tests++;
        if (rd !== 32'h08) begin
            n_fail++; $display("FAIL reset_sticky got %h exp 00000008", rd);
        end
        xfer(1, 5'h10, 32'h1, 0, 1, 0, rd, e);
        idle_cycle(0, 0);
        idle_cycle(1, 0);
    endtask

    initial begin
        test_reset();
        test_transfer();
        test_fifo();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1);
    end
endmodule
